// File: rtl/scan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_pkg : shared types, mode encoding and timing helpers for the raster scan
// Revision 1.0
// ----------------------------------------------------------------------------
package scan_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } scan_state_t;

  localparam logic [1:0] c_mode_pass   = 2'd0;
  localparam logic [1:0] c_mode_dither = 2'd1;
  localparam logic [1:0] c_mode_black  = 2'd2;
  localparam logic [1:0] c_mode_rsvd   = 2'd3;

  // One delay-line entry: everything that must stay aligned with the pixel.
  typedef struct packed {
    coord_t h;
    coord_t v;
    logic   blank;
    logic   hsync_n;
    logic   vsync_n;
    logic   frame_start;
    logic   dith;
    logic   black;
  } scan_tap_t;

  function automatic int scan_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Returns {dith, black}; the reserved code behaves as pass-through.
  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      c_mode_pass:   r = 2'b00;
      c_mode_dither: r = 2'b10;
      c_mode_black:  r = 2'b01;
      c_mode_rsvd:   r = 2'b00;
      default:       r = 2'b00;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_delay : fixed-depth shift register with a synchronous reset value
// Revision 1.0
// ----------------------------------------------------------------------------
module scan_delay #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dither_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dither_scan_ctrl : raster counters, framebuffer reads and pixel realignment
// Revision 1.0
// ----------------------------------------------------------------------------
module dither_scan_ctrl
  import scan_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int MEM_LAT  = 2,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [10:0]       hc,
  output logic [10:0]       vc,
  output logic [23:0]       pixel,
  output logic              dith_en,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              blank,
  output logic              frame_start,
  output logic              busy
);

  localparam int     c_h_total = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int     c_v_total = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam coord_t c_h_act   = coord_t'(H_ACTIVE);
  localparam coord_t c_v_act   = coord_t'(V_ACTIVE);
  localparam coord_t c_hs_lo   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t c_hs_hi   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t c_vs_lo   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t c_vs_hi   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t c_h_last  = coord_t'(c_h_total - 1);
  localparam coord_t c_v_last  = coord_t'(c_v_total - 1);

  localparam scan_tap_t c_idle_tap = '{h: '0, v: '0, blank: 1'b1, hsync_n: 1'b1,
                                       vsync_n: 1'b1, frame_start: 1'b0,
                                       dith: 1'b0, black: 1'b0};

  scan_state_t       r_state;
  coord_t            r_rh, r_rv;
  logic              r_dith, r_black;
  logic [ADDR_W-1:0] r_rd_cnt, r_mem_addr;
  logic              r_mem_rd;
  scan_tap_t         r_issue, w_tap, w_out;
  logic              w_run, w_rd, w_h_end, w_frame_end;
  logic [1:0]        w_mode_dec;

  assign w_run       = (r_state != ST_IDLE);
  assign w_rd        = w_run && (r_rh < c_h_act) && (r_rv < c_v_act);
  assign w_h_end     = (r_rh == c_h_last);
  assign w_frame_end = w_h_end && (r_rv == c_v_last);
  assign w_mode_dec  = decode_mode(mode);

  always_comb begin
    w_tap       = c_idle_tap;
    w_tap.h     = r_rh;
    w_tap.v     = r_rv;
    w_tap.dith  = r_dith;
    w_tap.black = r_black;
    if (w_run) begin
      w_tap.blank       = !w_rd;
      w_tap.hsync_n     = !((r_rh >= c_hs_lo) && (r_rh < c_hs_hi));
      w_tap.vsync_n     = !((r_rv >= c_vs_lo) && (r_rv < c_vs_hi));
      w_tap.frame_start = (r_rh == '0) && (r_rv == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rh       <= '0;
      r_rv       <= '0;
      r_dith     <= 1'b0;
      r_black    <= 1'b0;
      r_rd_cnt   <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_issue    <= c_idle_tap;
    end else begin
      r_mem_rd <= w_rd;
      r_issue  <= w_tap;
      if (w_rd) begin
        r_mem_addr <= r_rd_cnt;
        r_rd_cnt   <= r_rd_cnt + ADDR_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          r_rh     <= '0;
          r_rv     <= '0;
          r_rd_cnt <= '0;
          if (start && !stop) begin
            r_state <= ST_RUN;
            r_dith  <= w_mode_dec[1];
            r_black <= w_mode_dec[0];
          end
        end
        ST_RUN, ST_LAST: begin
          if (w_h_end) begin
            r_rh <= '0;
            if (r_rv == c_v_last) begin
              r_rv     <= '0;
              r_rd_cnt <= '0;
            end else begin
              r_rv <= r_rv + 11'd1;
            end
          end else begin
            r_rh <= r_rh + 11'd1;
          end
          // A stop seen on the very last raw cycle ends the current frame.
          if (w_frame_end) begin
            if ((r_state == ST_LAST) || stop) begin
              r_state <= ST_IDLE;
            end else begin
              r_dith  <= w_mode_dec[1];
              r_black <= w_mode_dec[0];
            end
          end else if ((r_state == ST_RUN) && stop) begin
            r_state <= ST_LAST;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  scan_delay #(
    .WIDTH  ($bits(scan_tap_t)),
    .DEPTH  (MEM_LAT),
    .RST_VAL(c_idle_tap)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .din  (r_issue),
    .dout (w_out)
  );

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign hc          = w_out.h;
  assign vc          = w_out.v;
  assign blank       = w_out.blank;
  assign hsync_n     = w_out.hsync_n;
  assign vsync_n     = w_out.vsync_n;
  assign frame_start = w_out.frame_start;
  assign dith_en     = w_out.dith;
  assign pixel       = (!w_out.blank && !w_out.black) ? mem_rdata : 24'h000000;
  assign busy        = w_run;

endmodule
`default_nettype wire

// File: tb/tb_dither_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dither_scan_ctrl : directed vector bench, full horizontal timing with a
// shortened vertical frame (4 active lines, 9 total) so two frames fit easily.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_dither_scan_ctrl;

  localparam int MEM_LAT = 2;
  localparam int ADDR_W  = 20;

  logic              clk = 1'b0;
  logic              reset, start, stop;
  logic [1:0]        mode;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_rdata;
  logic [10:0]       hc, vc;
  logic [23:0]       pixel;
  logic              dith_en, hsync_n, vsync_n, blank, frame_start, busy;

  dither_scan_ctrl #(
    .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .hc(hc), .vc(vc), .pixel(pixel), .dith_en(dith_en),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .blank(blank),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Framebuffer model: data = address, garbage when no read was issued.
  logic [23:0] mem_pipe [MEM_LAT];
  always @(posedge clk) begin
    mem_pipe[0] <= mem_rd ? 24'(mem_addr) : 24'hC0FFEE;
    for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_rdata = mem_pipe[MEM_LAT-1];

  typedef struct packed {
    logic        rd;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [23:0] px;
    logic        bl, hs, vs, fs, di, bu;
  } out_t;

  typedef struct {
    int         k;
    logic [1:0] mode;
    logic       start;
    logic       stop;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0, n_total = 0, cyc = 0;
  int   n_reads = 0;
  logic [ADDR_W-1:0] max_addr = '0;
  logic cnt_en = 1'b0;

  always @(negedge clk) begin
    if (cnt_en && mem_rd) begin
      n_reads++;
      if (mem_addr > max_addr) max_addr = mem_addr;
    end
  end

  // flags = {rd, blank, hsync_n, vsync_n, frame_start, dith_en, busy}
  function automatic out_t mk_out(input logic [6:0] f, input int h, input int v,
                                  input logic [23:0] px);
    out_t o;
    o.rd = f[6]; o.bl = f[5]; o.hs = f[4]; o.vs = f[3];
    o.fs = f[2]; o.di = f[1]; o.bu = f[0];
    o.hc = 11'(h); o.vc = 11'(v); o.px = px;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.rd = mem_rd; o.hc = hc; o.vc = vc; o.px = pixel; o.bl = blank;
    o.hs = hsync_n; o.vs = vsync_n; o.fs = frame_start; o.di = dith_en; o.bu = busy;
    return o;
  endfunction

  task automatic add(input int k, input int md, input int st, input int sp,
                     input logic [6:0] f, input int h, input int v, input logic [23:0] px);
    vec_t r;
    r.k = k; r.mode = 2'(md); r.start = (st != 0); r.stop = (sp != 0);
    r.exp = mk_out(f, h, v, px);
    vecs.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk_out(input string name, input out_t got, input out_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got rd=%b hc=%0d vc=%0d px=%h bl=%b hs=%b vs=%b fs=%b di=%b busy=%b ; expected rd=%b hc=%0d vc=%0d px=%h bl=%b hs=%b vs=%b fs=%b di=%b busy=%b",
                  name, got.rd, got.hc, got.vc, got.px, got.bl, got.hs, got.vs, got.fs, got.di, got.bu,
                  exp.rd, exp.hc, exp.vc, exp.px, exp.bl, exp.hs, exp.vs, exp.fs, exp.di, exp.bu);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  initial begin
    // k counts edges after the one that samples start; aligned position = k-3.
    add(    0, 1, 1, 0, 7'b0111001,    0, 0, 24'h0);
    add(    2, 1, 1, 0, 7'b1111001,    0, 0, 24'h0);
    add(    3, 1, 1, 0, 7'b1011111,    0, 0, 24'h0);
    add(    4, 1, 1, 0, 7'b1011011,    1, 0, 24'h1);
    add( 1026, 1, 1, 0, 7'b0011011, 1023, 0, 24'h3FF);
    add( 1027, 1, 1, 0, 7'b0111011, 1024, 0, 24'h0);
    add( 1050, 1, 1, 0, 7'b0111011, 1047, 0, 24'h0);
    add( 1051, 1, 1, 0, 7'b0101011, 1048, 0, 24'h0);
    add( 1186, 1, 1, 0, 7'b0101011, 1183, 0, 24'h0);
    add( 1187, 1, 1, 0, 7'b0111011, 1184, 0, 24'h0);
    add( 1346, 1, 1, 0, 7'b1111011, 1343, 0, 24'h0);
    add( 1347, 1, 1, 0, 7'b1011011,    0, 1, 24'h400);
    add( 2700, 2, 1, 0, 7'b1011011,    9, 2, 24'h809);
    add( 5058, 2, 1, 0, 7'b0011011, 1023, 3, 24'hFFF);
    add( 5379, 2, 1, 0, 7'b0111011,    0, 4, 24'h0);
    add( 6723, 2, 1, 0, 7'b0110011,    0, 5, 24'h0);
    add( 9410, 2, 1, 0, 7'b0110011, 1343, 6, 24'h0);
    add( 9411, 2, 1, 0, 7'b0111011,    0, 7, 24'h0);
    add(12098, 2, 1, 0, 7'b1111011, 1343, 8, 24'h0);
    add(12099, 2, 1, 0, 7'b1011101,    0, 0, 24'h0);
    add(13122, 2, 1, 0, 7'b0011001, 1023, 0, 24'h0);
    add(14787, 2, 1, 1, 7'b1011001,    0, 2, 24'h0);
    add(24191, 2, 1, 1, 7'b0111001, 1340, 8, 24'h0);
    add(24192, 2, 1, 1, 7'b0111000, 1341, 8, 24'h0);
    add(24194, 2, 1, 1, 7'b0111000, 1343, 8, 24'h0);
    add(24195, 2, 1, 1, 7'b0111000,    0, 0, 24'h0);
    add(24500, 2, 1, 1, 7'b0111000,    0, 0, 24'h0);

    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    repeat (3) step();
    chk_out("reset_state", sample(), mk_out(7'b0111000, 0, 0, 24'h0));
    chk_int("reset_mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    step();
    chk_out("idle_no_start", sample(), mk_out(7'b0111000, 0, 0, 24'h0));

    mode = 2'd1; start = 1'b1; cnt_en = 1'b1;
    cyc = -1;
    step();
    for (int i = 0; i < vecs.size(); i++) begin
      while (cyc < vecs[i].k) step();
      chk_out($sformatf("vec%0d_k%0d", i, vecs[i].k), sample(), vecs[i].exp);
      mode = vecs[i].mode; start = vecs[i].start; stop = vecs[i].stop;
    end
    cnt_en = 1'b0;
    chk_int("total_reads_two_frames", n_reads, 8192);
    chk_int("max_read_addr", int'(max_addr), 4095);

    // Reset in the middle of a pass-through frame, then restart.
    stop = 1'b0; start = 1'b1; mode = 2'd0;
    step();
    start = 1'b0;
    repeat (3188) step();
    chk_out("pre_reset_pos", sample(), mk_out(7'b1011001, 497, 2, 24'h9F1));
    reset = 1'b1;
    step();
    chk_out("mid_reset_state", sample(), mk_out(7'b0111000, 0, 0, 24'h0));
    chk_int("mid_reset_mem_addr", int'(mem_addr), 0);
    reset = 1'b0; start = 1'b1;
    step();
    chk_out("restart_k0", sample(), mk_out(7'b0111001, 0, 0, 24'h0));
    step();
    chk_out("restart_k1", sample(), mk_out(7'b1111001, 0, 0, 24'h0));
    step();
    chk_out("restart_k2", sample(), mk_out(7'b1111001, 0, 0, 24'h0));
    step();
    chk_out("restart_k3", sample(), mk_out(7'b1011101, 0, 0, 24'h0));
    step();
    chk_out("restart_k4", sample(), mk_out(7'b1011001, 1, 0, 24'h1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
